matrix_4x4_feeder: RTL and testbench
====================================

// Module: matrix_4x4_feeder
// PURPOSE
//  Source-side streamer for the 4x4 matrix multiplier. Accepts a whole A/B matrix pair in one
//  load beat and serialises it into 16 element pairs on the multiplier's a_in/b_in stream.
//  Two-slot ping-pong buffer: the next pair loads while the current pair streams, so frames run with no bubble.
// PARAMETERS
//  DW       12  element width (matches multiplier a_in/b_in)
//  B_COLMAJ 1   1: B streamed column-major; 0: row-major (A is always row-major)
//  CNT_W    16  width of frame_cnt
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  ld_valid   in   1       load request, matrix pair on ld_a/ld_b
//  ld_ready   out  1       a buffer slot is free
//  ld_a       in   16*DW   A packed; element i = A[i/4][i%4], bits [i*DW +: DW]
//  ld_b       in   16*DW   B packed, same layout
//  m_valid    out  1       element pair valid -> multiplier valid_in
//  m_ready    in   1       multiplier accepts   <- multiplier ready_out
//  a_out      out  DW      A element            -> multiplier a_in
//  b_out      out  DW      B element            -> multiplier b_in
//  m_last     out  1       high on beat 15 of a frame
//  frame_cnt  out  CNT_W   completed frames, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - State: full[1:0], wr_ptr, rd_ptr, idx[3:0], frame_cnt. FSM is derived:
//    IDLE = !full[rd_ptr]; STREAM = full[rd_ptr].
//  - Reset: full=0, wr_ptr=rd_ptr=0, idx=0, frame_cnt=0.
//    Outputs after reset: m_valid=0, m_last=0, a_out=b_out=0, ld_ready=1. Buffer data is not reset.
//  - ld_ready = !(full[0] & full[1]), from registers only.
//  - Load: ld_valid & ld_ready at an edge writes slot wr_ptr, sets full[wr_ptr], toggles wr_ptr.
//  - m_valid = full[rd_ptr]. First beat is valid the cycle after the load edge (latency 1).
//  - Beat k = idx:
//    a_out = A[k/4][k%4]; b_out = B[k%4][k/4] when B_COLMAJ=1, else B[k/4][k%4].
//    a_out = b_out = 0 whenever m_valid=0.
//  - Transfer = m_valid & m_ready; idx increments.
//    While m_valid & !m_ready, m_valid, a_out, b_out and m_last are held stable.
//    Once m_valid is high it never drops before its transfer.
//  - m_last = m_valid & (idx==15).
//    On the last transfer: full[rd_ptr] clears, rd_ptr toggles, idx=0, frame_cnt+1.
//  - Other slot full at the last transfer: m_valid stays 1 and the next frame's beat 0 follows in the next cycle.
//  - Load and last transfer in the same cycle: both take effect.
//    ld_ready reflects only start-of-cycle state, so a freed slot is offered one cycle later.
//  - Reset mid-frame: the partial frame is discarded with no m_last, and queued frames are lost.
//    The next load streams from element 0.
// TESTING
//  T1 reset, idle: m_valid=0, ld_ready=1, frame_cnt=0, a_out=b_out=0.
//  T2 load A[i]=i+1, B[i]=i+17, m_ready=1:
//     16 consecutive beats; beat0 a=1 b=17, beat1 a=2 b=21, beat4 a=5 b=18, beat15 a=16 b=32 with m_last=1.
//     Afterwards frame_cnt=1, m_valid=0.
//  T3 same as T2 with m_ready alternating 1/0:
//     outputs hold on every low cycle; 16 beats take 31-32 cycles; sequence identical to T2.
//  T4 two back-to-back loads, m_ready=1, third ld_valid held:
//     ld_ready=0 after the 2nd accept; frame 2 beat0 immediately follows frame 1 beat15.
//     3rd load is accepted one cycle after frame 1's last beat.
//  T5 rst for 1 cycle at beat 7 of a frame:
//     next cycle m_valid=0, ld_ready=1, frame_cnt=0; a new load restarts at element 0.
//  T6 CNT_W=2: stream 5 frames; frame_cnt reads 1,2,3,0,1.

Source files
------------

// File: rtl/matrix_4x4_feeder.sv
// matrix_4x4_feeder: ping-pong buffered streamer turning a loaded 4x4 A/B pair into 16 element beats
module matrix_4x4_feeder #(
    parameter int DW       = 12,
    parameter bit B_COLMAJ = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [16*DW-1:0] ld_a,
    input  logic [16*DW-1:0] ld_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
    output logic             m_last,
    output logic [CNT_W-1:0] frame_cnt
);
    logic [16*DW-1:0] a_buf [2];
    logic [16*DW-1:0] b_buf [2];
    logic [1:0] full;
    logic wr_ptr, rd_ptr, load, xfer, done;
    logic [3:0] idx, b_idx;
    always_comb begin
        ld_ready = ~&full;
        m_valid  = full[rd_ptr];
        m_last   = m_valid & (idx == 4'd15);
        load     = ld_valid & ld_ready;
        xfer     = m_valid & m_ready;
        done     = xfer & m_last;
        b_idx    = B_COLMAJ ? {idx[1:0], idx[3:2]} : idx;
        a_out    = m_valid ? a_buf[rd_ptr][idx*DW +: DW] : '0;
        b_out    = m_valid ? b_buf[rd_ptr][b_idx*DW +: DW] : '0;
    end
    always_ff @(posedge clk) begin
        if (load) begin
            a_buf[wr_ptr] <= ld_a;
            b_buf[wr_ptr] <= ld_b;
        end
    end
    // a load only ever targets an empty slot, so set and clear never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 2'b00;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            idx       <= 4'd0;
            frame_cnt <= '0;
        end else begin
            full      <= (full | (load ? 2'b01 << wr_ptr : 2'b00)) & ~(done ? 2'b01 << rd_ptr : 2'b00);
            wr_ptr    <= wr_ptr ^ load;
            rd_ptr    <= rd_ptr ^ done;
            idx       <= idx + 4'(xfer);
            frame_cnt <= frame_cnt + CNT_W'(done);
        end
    end
endmodule

// File: tb/tb_matrix_4x4_feeder.sv
// tb_matrix_4x4_feeder: scoreboard plus directed sequences for the matrix feeder
module tb_matrix_4x4_feeder;
    localparam int DW = 12;
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
    } exp_t;
    typedef struct {
        int k;
        int a;
        int b;
        int last;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, ld_valid = 1'b0, m_ready = 1'b0;
    logic ld_ready, m_valid, m_last;
    logic [16*DW-1:0] ld_a = '0, ld_b = '0;
    logic [DW-1:0] a_out, b_out;
    logic [1:0] frame_cnt;
    exp_t q[$];
    logic [DW-1:0] log_a[$], log_b[$], t2_a[$], t2_b[$];
    int checks = 0, fails = 0, vcyc = 0;
    bit stalled = 1'b0, accepted = 1'b0;
    logic [1:0] exp_cnt = 2'd0;
    vec_t tbl[4];
    int cnt_tbl[5];

    matrix_4x4_feeder #(.DW(DW), .B_COLMAJ(1'b1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_a(ld_a), .ld_b(ld_b), .m_valid(m_valid), .m_ready(m_ready),
        .a_out(a_out), .b_out(b_out), .m_last(m_last), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", n, act, req);
        end
    endfunction

    function automatic void monitor();
        if (rst) begin
            q.delete();
            exp_cnt = 2'd0;
            stalled = 1'b0;
            return;
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        if (m_valid) begin
            vcyc++;
            if (q.size() == 0) chk("unexpected_beat", 32'(m_valid), 32'(0));
            else begin
                chk("a_out", 32'(a_out), 32'(q[0].a));
                chk("b_out", 32'(b_out), 32'(q[0].b));
                chk("m_last", 32'(m_last), 32'(q[0].last));
                if (m_ready) begin
                    log_a.push_back(a_out);
                    log_b.push_back(b_out);
                    if (q[0].last) exp_cnt++;
                    void'(q.pop_front());
                end
            end
        end else begin
            chk("m_valid_drop", 32'(stalled), 32'(m_valid));
            chk("idle_outputs", 32'({a_out, b_out, m_last}), 32'(0));
        end
        stalled = m_valid && !m_ready;
        if (ld_valid && ld_ready) begin
            accepted = 1'b1;
            for (int k = 0; k < 16; k++)
                q.push_back('{a: ld_a[k*DW +: DW], b: ld_b[((k % 4) * 4 + k / 4)*DW +: DW], last: (k == 15)});
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mats(input int sa, input int sb, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            ld_a[i*DW +: DW] = rnd ? DW'($urandom) : DW'(sa + i);
            ld_b[i*DW +: DW] = rnd ? DW'($urandom) : DW'(sb + i);
        end
    endtask

    task automatic load();
        accepted = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) tick();
        chk("load_accepted", 32'(accepted), 32'(1));
        ld_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_valid || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(m_valid || q.size() != 0), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        bit alt;
        tbl[0] = '{0, 1, 17, 0};
        tbl[1] = '{1, 2, 21, 0};
        tbl[2] = '{4, 5, 18, 0};
        tbl[3] = '{15, 16, 32, 1};
        cnt_tbl = '{1, 2, 3, 0, 1};
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_ld_ready", 32'(ld_ready), 32'(1));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("rst_a_out", 32'(a_out), 32'(0));
        chk("rst_b_out", 32'(b_out), 32'(0));
        chk("rst_m_last", 32'(m_last), 32'(0));

        set_mats(1, 17, 1'b0);
        m_ready = 1'b1;
        log_a.delete();
        log_b.delete();
        load();
        chk("t2_latency_valid", 32'(m_valid), 32'(1));
        chk("t2_latency_a", 32'(a_out), 32'(1));
        drain(40);
        chk("t2_beats", 32'(log_a.size()), 32'(16));
        foreach (tbl[i]) begin
            if (tbl[i].k < log_a.size()) begin
                chk("t2_tbl_a", 32'(log_a[tbl[i].k]), 32'(tbl[i].a));
                chk("t2_tbl_b", 32'(log_b[tbl[i].k]), 32'(tbl[i].b));
            end
        end
        chk("t2_frame_cnt", 32'(frame_cnt), 32'(1));
        chk("t2_idle", 32'(m_valid), 32'(0));
        t2_a = log_a;
        t2_b = log_b;

        log_a.delete();
        log_b.delete();
        vcyc = 0;
        load();
        alt = 1'b1;
        for (n = 0; n < 80 && (m_valid || q.size() != 0); n++) begin
            m_ready = alt;
            alt = !alt;
            tick();
        end
        m_ready = 1'b1;
        chk("t3_drained", 32'(m_valid || q.size() != 0), 32'(0));
        chk("t3_cycles_in_range", 32'(vcyc >= 31 && vcyc <= 32), 32'(1));
        chk("t3_beats", 32'(log_a.size()), 32'(16));
        for (int i = 0; i < 16 && i < log_a.size(); i++) begin
            chk("t3_seq_a", 32'(log_a[i]), 32'(t2_a[i]));
            chk("t3_seq_b", 32'(log_b[i]), 32'(t2_b[i]));
        end
        chk("t3_frame_cnt", 32'(frame_cnt), 32'(2));

        set_mats(0, 0, 1'b1);
        load();
        set_mats(100, 200, 1'b0);
        ld_valid = 1'b1;
        accepted = 1'b0;
        tick();
        chk("t4_second_accept", 32'(accepted), 32'(1));
        chk("t4_ld_ready_full", 32'(ld_ready), 32'(0));
        set_mats(300, 400, 1'b0);
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 40) begin
            tick();
            n++;
            if (n == 14) chk("t4_f1_last", 32'(m_last), 32'(1));
            if (n == 15) begin
                chk("t4_f2_no_bubble", 32'(m_valid), 32'(1));
                chk("t4_f2_beat0_a", 32'(a_out), 32'(100));
                chk("t4_f2_beat0_last", 32'(m_last), 32'(0));
            end
        end
        chk("t4_third_accept_delay", 32'(n), 32'(16));
        ld_valid = 1'b0;
        drain(80);

        set_mats(500, 600, 1'b0);
        load();
        repeat (7) tick();
        chk("t5_beat7_a", 32'(a_out), 32'(507));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_m_valid", 32'(m_valid), 32'(0));
        chk("t5_ld_ready", 32'(ld_ready), 32'(1));
        chk("t5_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("t5_a_out", 32'(a_out), 32'(0));
        set_mats(700, 800, 1'b0);
        load();
        chk("t5_restart_a", 32'(a_out), 32'(700));
        chk("t5_restart_b", 32'(b_out), 32'(800));
        drain(40);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            set_mats(f * 16 + 1, f * 16 + 1000, 1'b0);
            load();
            drain(40);
            chk("t6_frame_cnt", 32'(frame_cnt), 32'(cnt_tbl[f]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
